// File: rtl/morse_seq_if.sv
// Character-request and code-register handshake between the Morse sequencer
// and its requester/code register.
interface morse_seq_if;
  logic       start;
  logic [3:0] char_len;
  logic [3:0] cntr_data;
  logic       shft_data;
  logic       char_load;
  logic       shft_cnt;
  logic       morse_out;
  logic       busy;
  logic       done;

  modport master (
    output start, char_len, cntr_data, shft_data,
    input  char_load, shft_cnt, morse_out, busy, done
  );

  modport slave (
    input  start, char_len, cntr_data, shft_data,
    output char_load, shft_cnt, morse_out, busy, done
  );
endinterface

// File: rtl/morse_seq_ctrl.sv
// Morse element sequencer: walks the code register one element at a time and
// keys dots, dashes and gaps using a prescaled unit timer.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | char_load strobe, code register captures the character
// CHECK   | decide next element, character gap or word space
// MARK    | tone on for 1 or 3 units, shift on the last cycle
// GAP     | 1-unit inter-element gap
// CHARGAP | 2 more units completing the 3-unit character gap
// SPACE   | 7-unit word space
// DONE    | one-cycle done pulse
module morse_seq_ctrl #(
  parameter int UNIT_CYCLES = 4
) (
  input logic     clock,
  input logic     reset,
  morse_seq_if.slave bus
);
  localparam int UW = $clog2(UNIT_CYCLES + 1);
  localparam logic [UW-1:0] PRESC_LAST = UW'(UNIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_MARK    = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_CHARGAP = 3'd5;
  localparam logic [2:0] S_SPACE   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [2:0]    units_q, units_d;
  logic [UW-1:0] presc_q;
  logic          space_q;
  logic          unit_tick, timer_end, timed;

  assign unit_tick = (presc_q == PRESC_LAST);
  assign timer_end = unit_tick && (units_q == 3'd1);
  assign timed     = (state_q == S_MARK) || (state_q == S_GAP) ||
                     (state_q == S_CHARGAP) || (state_q == S_SPACE);

  always_comb begin
    state_d = state_q;
    units_d = units_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (space_q) begin
          state_d = S_SPACE;
          units_d = 3'd7;
        end else if (bus.cntr_data == 4'd0) begin
          state_d = S_CHARGAP;
          units_d = 3'd2;
        end else begin
          state_d = S_MARK;
          units_d = bus.shft_data ? 3'd3 : 3'd1;
        end
      end
      S_MARK: begin
        if (timer_end) begin
          state_d = S_GAP;
          units_d = 3'd1;
        end
      end
      S_GAP:     if (timer_end) state_d = S_CHECK;
      S_CHARGAP: if (timer_end) state_d = S_DONE;
      S_SPACE:   if (timer_end) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      units_q <= 3'd0;
      space_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.start)
        space_q <= (bus.char_len == 4'd0);
      // Every state change restarts the unit timer with the new unit count.
      if (state_d != state_q) begin
        presc_q <= '0;
        units_q <= units_d;
      end else if (timed && unit_tick) begin
        presc_q <= '0;
        units_q <= units_q - 3'd1;
      end else if (timed) begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign bus.char_load = (state_q == S_LOAD);
  assign bus.shft_cnt  = (state_q == S_MARK) && timer_end;
  assign bus.morse_out = (state_q == S_MARK);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_morse_seq_ctrl.sv
// Bench for morse_seq_ctrl: one instance at 4 cycles/unit, one at 1 cycle/unit,
// each fed by a behavioural code register.
module tb_morse_seq_ctrl;
  logic clock;
  logic rst  [2];
  logic st   [2];
  logic [3:0] len_r  [2];
  logic [7:0] code_r [2];
  logic [3:0] cnt_m  [2];
  logic [7:0] sh_m   [2];
  logic cl [2], sc [2], mo [2], by [2], dn [2];

  int n_tests = 0;
  int n_fail  = 0;

  morse_seq_if if4 ();
  morse_seq_if if1 ();

  assign if4.start     = st[0];
  assign if4.char_len  = len_r[0];
  assign if4.cntr_data = cnt_m[0];
  assign if4.shft_data = sh_m[0][7];
  assign if1.start     = st[1];
  assign if1.char_len  = len_r[1];
  assign if1.cntr_data = cnt_m[1];
  assign if1.shft_data = sh_m[1][7];

  assign cl[0] = if4.char_load;  assign cl[1] = if1.char_load;
  assign sc[0] = if4.shft_cnt;   assign sc[1] = if1.shft_cnt;
  assign mo[0] = if4.morse_out;  assign mo[1] = if1.morse_out;
  assign by[0] = if4.busy;       assign by[1] = if1.busy;
  assign dn[0] = if4.done;       assign dn[1] = if1.done;

  morse_seq_ctrl #(.UNIT_CYCLES(4)) dut4 (.clock(clock), .reset(rst[0]), .bus(if4.slave));
  morse_seq_ctrl #(.UNIT_CYCLES(1)) dut1 (.clock(clock), .reset(rst[1]), .bus(if1.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Code register: load on char_load, shift MSB out and decrement on shft_cnt.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (cl[i]) begin
        cnt_m[i] <= len_r[i];
        sh_m[i]  <= code_r[i];
      end else if (sc[i]) begin
        sh_m[i]  <= sh_m[i] << 1;
        cnt_m[i] <= cnt_m[i] - 4'd1;
      end
    end
  end

  typedef struct {
    int load_c; int loads; int first_m; int last_m; int mcnt;
    int rises;  int shft;  int done_c;  int dones;  int busy_cnt;
  } stat_t;

  typedef struct {
    string name; int idx; logic [3:0] len; logic [7:0] code;
    int first_m; int last_m; int mcnt; int rises; int shft; int done_c;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the end of cycle 0.
  task automatic run_char(input int idx, input logic [3:0] len, input logic [7:0] code,
                          input bit hold, output stat_t s);
    logic prev_mo;
    s = '{load_c: -1, loads: 0, first_m: -1, last_m: -1, mcnt: 0,
          rises: 0, shft: 0, done_c: -1, dones: 0, busy_cnt: 0};
    prev_mo    = 1'b0;
    len_r[idx] = len;
    code_r[idx] = code;
    st[idx]    = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (!hold) st[idx] = 1'b0;
      if (cl[idx]) begin
        s.loads++;
        if (s.load_c < 0) s.load_c = k;
      end
      if (mo[idx]) begin
        s.mcnt++;
        if (s.first_m < 0) s.first_m = k;
        s.last_m = k;
        if (!prev_mo) s.rises++;
      end
      prev_mo = mo[idx];
      if (sc[idx]) s.shft++;
      if (by[idx]) s.busy_cnt++;
      if (dn[idx]) begin
        s.dones++;
        s.done_c = k;
        break;
      end
    end
  endtask

  vec_t  vecs [7];
  stat_t s;
  int    cnt;

  initial begin
    vecs[0] = '{"E_u4",     0, 4'd1, 8'h00, 3,  6,  4, 1, 1, 20};
    vecs[1] = '{"T_u4",     0, 4'd1, 8'h80, 3, 14, 12, 1, 1, 28};
    vecs[2] = '{"A_u4",     0, 4'd2, 8'h40, 3, 23, 16, 2, 2, 37};
    vecs[3] = '{"SPACE_u4", 0, 4'd0, 8'hFF, -1, -1, 0, 0, 0, 31};
    vecs[4] = '{"S_u4",     0, 4'd3, 8'h00, 3, 24, 12, 3, 3, 38};
    vecs[5] = '{"E_u1",     1, 4'd1, 8'h00, 3,  3,  1, 1, 1,  8};
    vecs[6] = '{"O_u1",     1, 4'd3, 8'hE0, 3, 15,  9, 3, 3, 20};

    // Reset dominates a simultaneous start.
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; st[i] = 1'b1; len_r[i] = 4'd1; code_r[i] = 8'h00;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_char_load", i), int'(cl[i]), 0);
      chk($sformatf("rst%0d_shft_cnt", i),  int'(sc[i]), 0);
      chk($sformatf("rst%0d_morse_out", i), int'(mo[i]), 0);
      chk($sformatf("rst%0d_busy", i),      int'(by[i]), 0);
      chk($sformatf("rst%0d_done", i),      int'(dn[i]), 0);
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; st[i] = 1'b0;
    end
    @(negedge clock);

    foreach (vecs[v]) begin
      run_char(vecs[v].idx, vecs[v].len, vecs[v].code, 1'b0, s);
      chk({vecs[v].name, "_load_cycle"}, s.load_c,   1);
      chk({vecs[v].name, "_loads"},      s.loads,    1);
      chk({vecs[v].name, "_first_mark"}, s.first_m,  vecs[v].first_m);
      chk({vecs[v].name, "_last_mark"},  s.last_m,   vecs[v].last_m);
      chk({vecs[v].name, "_mark_cnt"},   s.mcnt,     vecs[v].mcnt);
      chk({vecs[v].name, "_rises"},      s.rises,    vecs[v].rises);
      chk({vecs[v].name, "_shft_cnt"},   s.shft,     vecs[v].shft);
      chk({vecs[v].name, "_done_cycle"}, s.done_c,   vecs[v].done_c);
      chk({vecs[v].name, "_busy_cnt"},   s.busy_cnt, vecs[v].done_c);
      @(negedge clock);
      chk({vecs[v].name, "_idle_after"}, int'(by[vecs[v].idx]), 0);
    end

    // start held through the whole character and the DONE cycle: one character only.
    run_char(0, 4'd1, 8'h00, 1'b1, s);
    chk("hold_loads",      s.loads,  1);
    chk("hold_done_cycle", s.done_c, 20);
    chk("hold_dones",      s.dones,  1);
    @(negedge clock);
    st[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (cl[0] || by[0]) cnt++;
    end
    chk("hold_no_requeue", cnt, 0);

    // Reset in the middle of a "T" dash.
    len_r[0] = 4'd1; code_r[0] = 8'h80; st[0] = 1'b1;
    @(negedge clock);
    st[0] = 1'b0;
    repeat (7) @(negedge clock);
    chk("abort_in_mark", int'(mo[0]), 1);
    rst[0] = 1'b1;
    @(negedge clock);
    chk("abort_morse_out", int'(mo[0]), 0);
    chk("abort_busy",      int'(by[0]), 0);
    chk("abort_done",      int'(dn[0]), 0);
    rst[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (dn[0] || by[0]) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_char(0, 4'd1, 8'h80, 1'b0, s);
    chk("after_abort_first_mark", s.first_m, 3);
    chk("after_abort_mark_cnt",   s.mcnt,    12);
    chk("after_abort_shft",       s.shft,    1);
    chk("after_abort_done_cycle", s.done_c,  28);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
